// File: rtl/asel_pkg.sv
// Shared types for the operand-A select stage: forwarding tags, source indices
// and the occupancy states of the two-entry operand buffer.
package asel_pkg;

    typedef enum logic [1:0] {
        FWD_NONE = 2'b00,
        FWD_EX   = 2'b01,
        FWD_MEM  = 2'b10
    } fwd_t;

    localparam int SRC_RS1  = 0;
    localparam int SRC_PC   = 1;
    localparam int SRC_ZERO = 2;

    typedef enum logic [1:0] {
        BUF_EMPTY = 2'd0,
        BUF_ONE   = 2'd1,
        BUF_TWO   = 2'd2
    } buf_state_t;

    // Select width for n sources, never narrower than one bit.
    function automatic int sel_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/asel_skid_buf.sv
// Two-entry elastic buffer. The caller qualifies push/pop with its own
// handshake, so push never arrives while the buffer holds two entries.
module asel_skid_buf
    import asel_pkg::*;
#(
    parameter int W = 34
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output buf_state_t   state
);

    buf_state_t   state_next;
    logic [W-1:0] head;
    logic [W-1:0] tail;
    logic         load_head;
    logic         head_from_tail;
    logic         load_tail;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= BUF_EMPTY;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            BUF_EMPTY: if (push) state_next = BUF_ONE;
            BUF_ONE: begin
                if (push && !pop) state_next = BUF_TWO;
                else if (pop && !push) state_next = BUF_EMPTY;
            end
            BUF_TWO:   if (pop) state_next = BUF_ONE;
            default:   state_next = BUF_EMPTY;
        endcase
    end

    // Push+pop in ONE writes straight into the head so it is visible next cycle.
    always_comb begin
        load_head      = 1'b0;
        head_from_tail = 1'b0;
        load_tail      = 1'b0;
        case (state)
            BUF_EMPTY: load_head = push;
            BUF_ONE: begin
                load_head = push && pop;
                load_tail = push && !pop;
            end
            BUF_TWO: begin
                load_head      = pop;
                head_from_tail = pop;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head <= '0;
            tail <= '0;
        end else begin
            if (load_head) head <= head_from_tail ? tail : din;
            if (load_tail) tail <= din;
        end
    end

    assign dout = head;

endmodule

// File: rtl/asel_fwd_buf.sv
// Operand-A select with EX/MEM forwarding onto the rs1 source, registered in
// a two-entry elastic buffer. Forwarding is built only when ASEL_FWD_EN is defined.
module asel_fwd_buf
    import asel_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int NSRC = 4,
    parameter int SELW = sel_width(NSRC)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [SELW-1:0]      in_sel,
    input  logic [NSRC*XLEN-1:0] in_src,
    input  logic [4:0]           in_rs1,
    input  logic                 ex_wr_en,
    input  logic [4:0]           ex_rd,
    input  logic [XLEN-1:0]      ex_data,
    input  logic                 mem_wr_en,
    input  logic [4:0]           mem_rd,
    input  logic [XLEN-1:0]      mem_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [XLEN-1:0]      out_data,
    output logic [1:0]           out_fwd,
    output logic                 sel_err
);

    logic [XLEN-1:0] sel_data;
    logic            sel_bad;
    logic [XLEN-1:0] pay_data;
    fwd_t            pay_fwd;
    logic [XLEN+1:0] head;
    buf_state_t      buf_state;
    logic            push;
    logic            pop;

    // An out-of-range select matches no source and yields zero.
    always_comb begin
        sel_data = '0;
        sel_bad  = 1'b1;
        for (int k = 0; k < NSRC; k++) begin
            if (in_sel == SELW'(k)) begin
                sel_data = in_src[k*XLEN +: XLEN];
                sel_bad  = 1'b0;
            end
        end
    end

`ifdef ASEL_FWD_EN
    always_comb begin
        pay_data = sel_data;
        pay_fwd  = FWD_NONE;
        if (in_sel == SELW'(SRC_RS1) && in_rs1 != 5'd0) begin
            if (ex_wr_en && ex_rd == in_rs1) begin
                pay_data = ex_data;
                pay_fwd  = FWD_EX;
            end else if (mem_wr_en && mem_rd == in_rs1) begin
                pay_data = mem_data;
                pay_fwd  = FWD_MEM;
            end
        end
    end
`else
    logic unused_fwd;
    assign unused_fwd = ^{ex_wr_en, ex_rd, ex_data, mem_wr_en, mem_rd, mem_data, in_rs1};

    always_comb begin
        pay_data = sel_data;
        pay_fwd  = FWD_NONE;
    end
`endif

    // Ready comes from registered occupancy only, never from out_ready.
    assign in_ready  = (buf_state != BUF_TWO);
    assign out_valid = (buf_state != BUF_EMPTY);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    asel_skid_buf #(
        .W (XLEN + 2)
    ) u_buf (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   ({pay_fwd, pay_data}),
        .dout  (head),
        .state (buf_state)
    );

    assign out_data = head[XLEN-1:0];
    assign out_fwd  = head[XLEN+1:XLEN];

    always_ff @(posedge clk) begin
        if (rst) begin
            sel_err <= 1'b0;
        end else if (push && sel_bad) begin
            sel_err <= 1'b1;
        end
    end

endmodule
